// File: rtl/kernel_fdtd_2d_mul_pipe.sv
// Pipelined multiplier with valid tracking, clock-enable stall and configurable narrowing.
// Define KERNEL_FDTD_2D_MUL_SAT_EN to saturate (instead of wrap) when dout_WIDTH < din0_WIDTH+din1_WIDTH.
module kernel_fdtd_2d_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 20,
    parameter int SIGNED     = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  busy
);
    localparam int   P  = din0_WIDTH + din1_WIDTH;
    localparam logic SX = (SIGNED != 0);

    if (NUM_STAGE < 1 || NUM_STAGE > 8 || ID < 0) begin : g_bad_param
        $error("kernel_fdtd_2d_mul_pipe ID=%0d: NUM_STAGE=%0d outside 1..8", ID, NUM_STAGE);
    end

    logic [NUM_STAGE-1:0]  vld_q;
    logic [din0_WIDTH-1:0] ma;
    logic [din1_WIDTH-1:0] mb;
    logic [P-1:0]          ext_a;
    logic [P-1:0]          ext_b;
    logic [P-1:0]          prod;
    logic [P-1:0]          fin;
    logic [dout_WIDTH-1:0] nar;
    logic [dout_WIDTH-1:0] dout_q;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q[0] <= in_vld;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // With a single stage the multiply consumes the raw inputs; otherwise stage 1 only registers operands.
    if (NUM_STAGE == 1) begin : g_mul_s1
        assign ma = din0;
        assign mb = din1;
    end else begin : g_mul_s2
        logic [din0_WIDTH-1:0] a_q;
        logic [din1_WIDTH-1:0] b_q;
        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (ce) begin
                a_q <= din0;
                b_q <= din1;
            end
        end
        assign ma = a_q;
        assign mb = b_q;
    end

    // Extending both operands to P bits makes a P-bit multiply exact for either signedness.
    always_comb begin
        ext_a                   = {P{SX & ma[din0_WIDTH-1]}};
        ext_a[din0_WIDTH-1:0]   = ma;
        ext_b                   = {P{SX & mb[din1_WIDTH-1]}};
        ext_b[din1_WIDTH-1:0]   = mb;
        prod                    = ext_a * ext_b;
    end

    if (NUM_STAGE <= 2) begin : g_no_retime
        assign fin = prod;
    end else begin : g_retime
        logic [P-1:0] mid_q [NUM_STAGE-2];
        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                for (int unsigned i = 0; i < NUM_STAGE - 2; i++) begin
                    mid_q[i] <= '0;
                end
            end else if (ce) begin
                mid_q[0] <= prod;
                for (int unsigned i = 1; i < NUM_STAGE - 2; i++) begin
                    mid_q[i] <= mid_q[i-1];
                end
            end
        end
        assign fin = mid_q[NUM_STAGE-3];
    end

    if (dout_WIDTH >= P) begin : g_extend
        always_comb begin
            nar        = {dout_WIDTH{SX & fin[P-1]}};
            nar[P-1:0] = fin;
        end
    end else begin : g_narrow
`ifdef KERNEL_FDTD_2D_MUL_SAT_EN
        if (SIGNED != 0) begin : g_sat_s
            logic [P-dout_WIDTH:0] hi;
            assign hi = fin[P-1:dout_WIDTH-1];
            // In range only when every discarded bit equals the new sign bit.
            always_comb begin
                if ((&hi) || !(|hi)) begin
                    nar = fin[dout_WIDTH-1:0];
                end else begin
                    nar                 = '1;
                    nar[dout_WIDTH-1]   = 1'b0;
                    if (fin[P-1]) nar   = ~nar;
                end
            end
        end else begin : g_sat_u
            always_comb begin
                nar = (|fin[P-1:dout_WIDTH]) ? '1 : fin[dout_WIDTH-1:0];
            end
        end
`else
        assign nar = fin[dout_WIDTH-1:0];
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            dout_q <= '0;
        end else if (ce) begin
            dout_q <= nar;
        end
    end

    assign dout    = dout_q;
    assign out_vld = vld_q[NUM_STAGE-1];
    assign busy    = |vld_q;

endmodule
